// File: rtl/param_datapath.sv
// Register file + ALU datapath with a two-stage issue/execute pipeline, operand forwarding,
// an iterative shift-add multiplier and an independent program counter.
module param_datapath #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int PC_W     = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        OpCode,
  input  logic [REG_AW-1:0] RegDst,
  input  logic [REG_AW-1:0] RegSrc,
  input  logic              UseImm,
  input  logic [DATA_W-1:0] Imm,
  output logic              OutValid,
  output logic [DATA_W-1:0] Result,
  output logic [3:0]        Flags,
  input  logic              PcEn,
  input  logic              PcLd,
  input  logic [PC_W-1:0]   PcIn,
  output logic [PC_W-1:0]   PcOut,
  input  logic [REG_AW-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int MSB   = DATA_W - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {ST_RUN, ST_MUL} state_t;

  // Returns {F, N, Z, C, result}; MUL is handled by the iterative unit, not here.
  function automatic logic [DATA_W+3:0] alu_eval(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] r;
    logic              c;
    logic              f;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    f    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[DATA_W-1:0];
        c    = wide[DATA_W];
        f    = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        r = a - b;
        c = (a < b);
        f = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MOV:  r = b;
      default: r = '0;
    endcase
    return {f, r[MSB], (r == '0), c, r};
  endfunction

  state_t              state_q, state_d;
  logic                vld_p1_q, vld_p1_d;
  logic [2:0]          op_p1_q, op_p1_d;
  logic [REG_AW-1:0]   dst_p1_q, dst_p1_d;
  logic [DATA_W-1:0]   a_p1_q, a_p1_d;
  logic [DATA_W-1:0]   b_p1_q, b_p1_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   rf_d [NUM_REGS];
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                out_vld_q, out_vld_d;
  logic [PC_W-1:0]     pc_q, pc_d;

  logic [DATA_W+3:0]   alu_out;
  logic [DATA_W-1:0]   step_sum;
  logic                wb_en;
  logic                rf_we;
  logic [DATA_W-1:0]   wb_res;
  logic [3:0]          wb_flags;
  logic                in_ready;
  logic                accept;

  always_comb begin
    state_d  = state_q;
    vld_p1_d = 1'b0;
    op_p1_d  = op_p1_q;
    dst_p1_d = dst_p1_q;
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    rf_d     = rf_q;
    result_d = result_q;
    flags_d  = flags_q;
    pc_d     = pc_q;

    // Stage E2: single-cycle ALU or one shift-add step of MUL
    alu_out  = alu_eval(op_p1_q, a_p1_q, b_p1_q);
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    wb_en    = 1'b0;
    wb_res   = alu_out[DATA_W-1:0];
    wb_flags = alu_out[DATA_W+3:DATA_W];

    case (state_q)
      ST_RUN: begin
        if (vld_p1_q) begin
          if (op_p1_q == OP_MUL) begin
            // First partial product is taken here so DATA_W steps end DATA_W cycles after issue.
            acc_d    = b_p1_q[0] ? a_p1_q : '0;
            mcand_d  = a_p1_q << 1;
            mplier_d = b_p1_q >> 1;
            cnt_d    = CNT_W'(1);
            state_d  = ST_MUL;
          end else begin
            wb_en = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          wb_en    = 1'b1;
          wb_res   = step_sum;
          wb_flags = {1'b0, step_sum[MSB], (step_sum == '0), 1'b0};
          state_d  = ST_RUN;
        end else begin
          acc_d    = step_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    rf_we     = wb_en && (op_p1_q != OP_CMP);
    out_vld_d = wb_en;
    if (wb_en) begin
      result_d = wb_res;
      flags_d  = wb_flags;
    end
    if (rf_we) rf_d[dst_p1_q] = wb_res;

    // Stage E1: operand fetch with forwarding from the E2 writeback
    in_ready = (state_q == ST_RUN) && !(vld_p1_q && (op_p1_q == OP_MUL));
    accept   = InValid && in_ready;
    if (accept) begin
      vld_p1_d = 1'b1;
      op_p1_d  = OpCode;
      dst_p1_d = RegDst;
      a_p1_d   = (rf_we && (dst_p1_q == RegDst)) ? wb_res : rf_q[RegDst];
      if (UseImm)
        b_p1_d = Imm;
      else
        b_p1_d = (rf_we && (dst_p1_q == RegSrc)) ? wb_res : rf_q[RegSrc];
    end

    if (PcLd)
      pc_d = PcIn;
    else if (PcEn)
      pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_RUN;
      vld_p1_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      out_vld_q <= 1'b0;
      pc_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      vld_p1_q  <= vld_p1_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      out_vld_q <= out_vld_d;
      pc_q      <= pc_d;
      rf_q      <= rf_d;
    end
  end

  // Operand and multiplier datapath registers are qualified by the control state above.
  always_ff @(posedge Clk) begin
    op_p1_q  <= op_p1_d;
    dst_p1_q <= dst_p1_d;
    a_p1_q   <= a_p1_d;
    b_p1_q   <= b_p1_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign InReady  = in_ready;
  assign OutValid = out_vld_q;
  assign Result   = result_q;
  assign Flags    = flags_q;
  assign PcOut    = pc_q;
  assign DbgData  = rf_q[DbgAddr];

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath: an ISA-level register model feeds a scoreboard of
// expected Result/Flags/latency that is drained whenever OutValid pulses.
module tb_param_datapath;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int PW = 10;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [2:0]    OpCode = '0;
  logic [AW-1:0] RegDst = '0;
  logic [AW-1:0] RegSrc = '0;
  logic          UseImm = 1'b0;
  logic [DW-1:0] Imm = '0;
  logic          OutValid;
  logic [DW-1:0] Result;
  logic [3:0]    Flags;
  logic          PcEn = 1'b0;
  logic          PcLd = 1'b0;
  logic [PW-1:0] PcIn = '0;
  logic [PW-1:0] PcOut;
  logic [AW-1:0] DbgAddr = '0;
  logic [DW-1:0] DbgData;

  param_datapath #(.DATA_W(DW), .NUM_REGS(NR), .PC_W(PW)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .OpCode(OpCode),
    .RegDst(RegDst), .RegSrc(RegSrc), .UseImm(UseImm), .Imm(Imm), .OutValid(OutValid),
    .Result(Result), .Flags(Flags), .PcEn(PcEn), .PcLd(PcLd), .PcIn(PcIn), .PcOut(PcOut),
    .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic [3:0]    flg;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mr[NR];
  int            checks = 0;
  int            failures = 0;
  int            ov_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic dbg(input string tag, input int r, input logic [DW-1:0] exp);
    DbgAddr = AW'(r);
    #1;
    chk(tag, DbgData, exp);
  endtask

  // Architectural model: computes the expected outcome and updates the model register file.
  task automatic model(input logic [2:0] op, input int dst, input int src, input logic ui,
                       input logic [DW-1:0] imm, input int lat);
    logic [DW-1:0] a, b, r;
    logic          c, f;
    int            s, sa, sb_i, ss;
    exp_t          e;
    a = mr[dst];
    b = ui ? imm : mr[src];
    sa = int'($signed(a));
    sb_i = int'($signed(b));
    c = 1'b0;
    f = 1'b0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        r = s[DW-1:0];
        c = (s > 65535);
        ss = sa + sb_i;
        f = (ss > 32767) || (ss < -32768);
      end
      3'd1, 3'd6: begin
        r = a - b;
        c = (int'(a) < int'(b));
        ss = sa - sb_i;
        f = (ss > 32767) || (ss < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      default: r = a * b;
    endcase
    if (op != 3'd6) mr[dst] = r;
    e.res = r;
    e.flg = {f, r[DW-1], (r == '0), c};
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // Present an op from posedge+1, wait (bounded) for acceptance, then record the expectation.
  task automatic issue(input logic [2:0] op, input int dst, input int src, input logic ui,
                       input logic [DW-1:0] imm, input int lat, output int waited);
    OpCode  = op;
    RegDst  = AW'(dst);
    RegSrc  = AW'(src);
    UseImm  = ui;
    Imm     = imm;
    InValid = 1'b1;
    waited  = 0;
    @(negedge Clk);
    while (!InReady && waited < 100) begin
      waited++;
      @(negedge Clk);
    end
    if (!InReady) chk("accept_timeout", InReady, 1);
    model(op, dst, src, ui, imm, lat);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (Reset && OutValid) begin
      exp_t e;
      ov_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_outvalid", OutValid, 0);
      end else begin
        e = sb.pop_front();
        chk("result", Result, e.res);
        chk("flags", Flags, e.flg);
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int w;
    int n;
    for (int i = 0; i < NR; i++) mr[i] = '0;

    // Reset for one cycle
    Reset = 1'b0;
    align();
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_pc", PcOut, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_result", Result, 0);
    chk("rst_inready", InReady, 1);
    chk("rst_outvalid", OutValid, 0);
    for (int i = 0; i < NR; i++) begin
      DbgAddr = AW'(i);
      #0.1;
      chk($sformatf("rst_r%0d", i), DbgData, 0);
    end
    align();

    // Back-to-back with forwarding
    issue(3'd5, 1, 0, 1'b1, 16'd5, 2, w);
    issue(3'd0, 1, 1, 1'b0, 16'd0, 2, w);
    settle(4);
    dbg("fwd_r1", 1, 16'd10);
    chk("fwd_flags", Flags, 4'b0000);
    align();

    // Signed overflow then compare
    issue(3'd5, 2, 0, 1'b1, 16'h7FFF, 2, w);
    issue(3'd0, 2, 0, 1'b1, 16'h0001, 2, w);
    settle(3);
    chk("ovf_flags", Flags, 4'b1100);
    align();
    issue(3'd6, 2, 0, 1'b1, 16'h8000, 2, w);
    settle(3);
    chk("cmp_flags", Flags, 4'b0010);
    dbg("cmp_r2_unchanged", 2, 16'h8000);
    align();

    // Logic ops and register-sourced operands
    issue(3'd1, 6, 0, 1'b1, 16'h0001, 2, w);
    issue(3'd2, 6, 0, 1'b1, 16'h0F0F, 2, w);
    issue(3'd3, 6, 0, 1'b1, 16'h3000, 2, w);
    issue(3'd4, 6, 1, 1'b0, 16'h0000, 2, w);
    issue(3'd5, 7, 6, 1'b0, 16'h0000, 2, w);
    settle(4);
    dbg("logic_r6", 6, 16'h3F05);
    dbg("mov_r7", 7, 16'h3F05);
    align();

    // Multi-cycle multiply with an op held through the stall
    issue(3'd5, 3, 0, 1'b1, 16'd300, 2, w);
    issue(3'd7, 3, 0, 1'b1, 16'd7, 17, w);
    issue(3'd5, 4, 3, 1'b0, 16'd0, 2, w);
    chk("mul_stall_cycles", w, 16);
    settle(4);
    dbg("mul_r3", 3, 16'd2100);
    dbg("held_op_r4", 4, 16'd2100);
    align();

    // Program counter
    PcLd = 1'b1;
    PcIn = 10'h3FF;
    align();
    PcLd = 1'b0;
    chk("pc_load", PcOut, 10'h3FF);
    PcEn = 1'b1;
    align();
    chk("pc_wrap", PcOut, 10'h000);
    PcLd = 1'b1;
    PcIn = 10'h123;
    align();
    chk("pc_ld_priority", PcOut, 10'h123);
    PcLd = 1'b0;
    align();
    chk("pc_inc", PcOut, 10'h124);
    PcEn = 1'b0;
    align();
    chk("pc_hold", PcOut, 10'h124);

    // Reset in the middle of a multiply
    issue(3'd5, 5, 0, 1'b1, 16'd3, 2, w);
    issue(3'd7, 5, 0, 1'b1, 16'd5, 17, w);
    settle(5);
    Reset = 1'b0;
    align();
    Reset = 1'b1;
    sb.delete();
    for (int i = 0; i < NR; i++) mr[i] = '0;
    n = ov_cnt;
    settle(25);
    chk("midmul_no_outvalid", ov_cnt, n);
    dbg("midmul_r5", 5, 16'd0);
    chk("midmul_inready", InReady, 1);
    chk("midmul_result", Result, 0);
    align();

    // Normal operation after reset
    issue(3'd5, 5, 0, 1'b1, 16'd9, 2, w);
    settle(4);
    dbg("post_rst_r5", 5, 16'd9);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
